// File: rtl/pifo_pkg.sv
// Shared definitions for the PIFO scheduler and its STFQ rank stamper:
// widths, the {tag, payload} push-data layout and modular tag comparison.
package pifo_pkg;

  localparam int NUM_FLOWS     = 16;
  localparam int MAX_PRIORITY  = 256;
  localparam int PAYLOAD_WIDTH = 8;
  localparam int LEN_WIDTH     = 8;
  localparam int VT_WIDTH      = 16;
  localparam int SHIFT_WIDTH   = 3;

  localparam int FLOW_WIDTH = $clog2(NUM_FLOWS);
  localparam int PRIO_WIDTH = $clog2(MAX_PRIORITY);
  localparam int DATA_WIDTH = VT_WIDTH + PAYLOAD_WIDTH;

  localparam logic [PRIO_WIDTH-1:0] PRIO_TOP = PRIO_WIDTH'(MAX_PRIORITY - 1);

  typedef logic [VT_WIDTH-1:0] vt_t;

  typedef struct packed {
    vt_t                      tag;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } stamp_entry_t;

  // True when a is strictly later than b in modular (half-range) time.
  function automatic logic tag_after(input vt_t a, input vt_t b);
    vt_t d;
    d = a - b;
    return (d != '0) && !d[VT_WIDTH-1];
  endfunction

  // Offset from V to PIFO priority: offset 0 is the most urgent, saturating at 1.
  function automatic logic [PRIO_WIDTH-1:0] offset_to_prio(input vt_t off);
    if (off >= vt_t'(MAX_PRIORITY - 1))
      return PRIO_WIDTH'(1);
    else
      return PRIO_TOP - off[PRIO_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/pifo_rank_stamper_table.sv
// Per-flow finish-tag table (and, with PIFO_RANK_WEIGHT_EN, per-flow length
// shift table): one combinational read port, one write port, synchronous clear.
module stfq_tag_table
  import pifo_pkg::*;
(
  input  logic                   clk,
  input  logic                   clear,
  input  logic [FLOW_WIDTH-1:0]  rd_flow,
  output vt_t                    rd_tag,
  input  logic                   wr_en,
  input  logic [FLOW_WIDTH-1:0]  wr_flow,
  input  vt_t                    wr_tag
`ifdef PIFO_RANK_WEIGHT_EN
  ,
  output logic [SHIFT_WIDTH-1:0] rd_shift,
  input  logic                   cfg_valid,
  input  logic [FLOW_WIDTH-1:0]  cfg_flow,
  input  logic [SHIFT_WIDTH-1:0] cfg_shift
`endif
);

  vt_t finish_tag [NUM_FLOWS];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < NUM_FLOWS; i++) finish_tag[i] <= '0;
    end else if (wr_en) begin
      finish_tag[wr_flow] <= wr_tag;
    end
  end

  assign rd_tag = finish_tag[rd_flow];

`ifdef PIFO_RANK_WEIGHT_EN
  logic [SHIFT_WIDTH-1:0] weight_shift [NUM_FLOWS];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < NUM_FLOWS; i++) weight_shift[i] <= '0;
    end else if (cfg_valid) begin
      weight_shift[cfg_flow] <= cfg_shift;
    end
  end

  assign rd_shift = weight_shift[rd_flow];
`endif

endmodule

// File: rtl/pifo_rank_stamper.sv
// STFQ rank stamper in front of pifo_base: assigns start tags, maps them to
// PIFO priorities and tracks virtual time. Optional macro PIFO_RANK_WEIGHT_EN
// adds per-flow length shifts.
module pifo_rank_stamper
  import pifo_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i__pkt_valid,
  input  logic [FLOW_WIDTH-1:0]    i__pkt_flow,
  input  logic [LEN_WIDTH-1:0]     i__pkt_len,
  input  logic [PAYLOAD_WIDTH-1:0] i__pkt_payload,
  output logic                     o__pkt_ready,
  output logic                     o__push_valid,
  output logic [PRIO_WIDTH-1:0]    o__push_priority,
  output logic [DATA_WIDTH-1:0]    o__push_data,
  input  logic                     i__enqueue_ready,
  input  logic                     i__deq_valid,
  input  logic [VT_WIDTH-1:0]      i__deq_tag,
  input  logic                     i__clear_all,
`ifdef PIFO_RANK_WEIGHT_EN
  input  logic                     i__cfg_valid,
  input  logic [FLOW_WIDTH-1:0]    i__cfg_flow,
  input  logic [SHIFT_WIDTH-1:0]   i__cfg_shift,
`endif
  output logic [VT_WIDTH-1:0]      o__virtual_time
);

  // Handshakes: a packet transfers in when i__pkt_valid & o__pkt_ready at a
  // rising edge; the push register transfers out when o__push_valid &
  // i__enqueue_ready, and holds priority/data stable until then.

  logic                  flush;
  logic                  accept;
  vt_t                   virtual_time;
  vt_t                   flow_finish;
  vt_t                   start_tag;
  vt_t                   incr;
  vt_t                   next_finish;
  logic [PRIO_WIDTH-1:0] stamp_prio;
  logic                  push_valid;
  logic [PRIO_WIDTH-1:0] push_priority;
  stamp_entry_t          push_entry;

  assign flush        = reset | i__clear_all;
  assign o__pkt_ready = ~reset & (~push_valid | i__enqueue_ready);
  assign accept       = i__pkt_valid & o__pkt_ready;

`ifdef PIFO_RANK_WEIGHT_EN
  logic [SHIFT_WIDTH-1:0] flow_shift;

  stfq_tag_table u_table (
    .clk       (clk),
    .clear     (flush),
    .rd_flow   (i__pkt_flow),
    .rd_tag    (flow_finish),
    .wr_en     (accept & ~i__clear_all),
    .wr_flow   (i__pkt_flow),
    .wr_tag    (next_finish),
    .rd_shift  (flow_shift),
    .cfg_valid (i__cfg_valid),
    .cfg_flow  (i__cfg_flow),
    .cfg_shift (i__cfg_shift)
  );

  assign incr = vt_t'(i__pkt_len) >> flow_shift;
`else
  stfq_tag_table u_table (
    .clk     (clk),
    .clear   (flush),
    .rd_flow (i__pkt_flow),
    .rd_tag  (flow_finish),
    .wr_en   (accept & ~i__clear_all),
    .wr_flow (i__pkt_flow),
    .wr_tag  (next_finish)
  );

  assign incr = vt_t'(i__pkt_len);
`endif

  // A finish tag that is not ahead of V (idle flow, or wrapped) restarts at V.
  always_comb begin
    start_tag   = tag_after(flow_finish, virtual_time) ? flow_finish : virtual_time;
    next_finish = start_tag + incr;
    stamp_prio  = offset_to_prio(start_tag - virtual_time);
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      push_valid    <= 1'b0;
      push_priority <= '0;
      push_entry    <= '0;
    end else if (accept) begin
      push_valid         <= 1'b1;
      push_priority      <= stamp_prio;
      push_entry.tag     <= start_tag;
      push_entry.payload <= i__pkt_payload;
    end else if (push_valid && i__enqueue_ready) begin
      push_valid <= 1'b0;
    end
  end

  // V only moves forward; accepts in the same cycle already used the old V.
  always_ff @(posedge clk) begin
    if (flush) begin
      virtual_time <= '0;
    end else if (i__deq_valid && tag_after(i__deq_tag, virtual_time)) begin
      virtual_time <= i__deq_tag;
    end
  end

  assign o__push_valid    = push_valid;
  assign o__push_priority = push_priority;
  assign o__push_data     = push_entry;
  assign o__virtual_time  = virtual_time;

endmodule

// File: tb/tb_pifo_rank_stamper.sv
// Directed bench for pifo_rank_stamper with an expected-push scoreboard;
// weight checks follow PIFO_RANK_WEIGHT_EN.
module tb_pifo_rank_stamper;

  logic        clk;
  logic        reset;
  logic        i__pkt_valid;
  logic [3:0]  i__pkt_flow;
  logic [7:0]  i__pkt_len;
  logic [7:0]  i__pkt_payload;
  logic        o__pkt_ready;
  logic        o__push_valid;
  logic [7:0]  o__push_priority;
  logic [23:0] o__push_data;
  logic        i__enqueue_ready;
  logic        i__deq_valid;
  logic [15:0] i__deq_tag;
  logic        i__clear_all;
  logic [15:0] o__virtual_time;
`ifdef PIFO_RANK_WEIGHT_EN
  logic        i__cfg_valid;
  logic [3:0]  i__cfg_flow;
  logic [2:0]  i__cfg_shift;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] dropped;

  pifo_rank_stamper dut (
    .clk              (clk),
    .reset            (reset),
    .i__pkt_valid     (i__pkt_valid),
    .i__pkt_flow      (i__pkt_flow),
    .i__pkt_len       (i__pkt_len),
    .i__pkt_payload   (i__pkt_payload),
    .o__pkt_ready     (o__pkt_ready),
    .o__push_valid    (o__push_valid),
    .o__push_priority (o__push_priority),
    .o__push_data     (o__push_data),
    .i__enqueue_ready (i__enqueue_ready),
    .i__deq_valid     (i__deq_valid),
    .i__deq_tag       (i__deq_tag),
    .i__clear_all     (i__clear_all),
`ifdef PIFO_RANK_WEIGHT_EN
    .i__cfg_valid     (i__cfg_valid),
    .i__cfg_flow      (i__cfg_flow),
    .i__cfg_shift     (i__cfg_shift),
`endif
    .o__virtual_time  (o__virtual_time)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one packet; expected push word is {prio, tag, payload}.
  task automatic send(input logic [3:0] flow, input logic [7:0] len, input logic [7:0] pl,
                      input logic [7:0] prio, input logic [15:0] tag);
    int waited;
    i__pkt_valid   = 1'b1;
    i__pkt_flow    = flow;
    i__pkt_len     = len;
    i__pkt_payload = pl;
    #1;
    waited = 0;
    while (!o__pkt_ready && waited < 50) begin
      @(posedge clk);
      #2;
      waited++;
    end
    if (waited >= 50) begin
      errors++;
      $display("FAIL send_timeout: observed=not_ready expected=ready flow=%0d", flow);
    end
    exp_q.push_back({prio, tag, pl});
    @(posedge clk);
    #1;
    i__pkt_valid = 1'b0;
  endtask

  task automatic deq(input logic [15:0] tag);
    i__deq_valid = 1'b1;
    i__deq_tag   = tag;
    tick();
    i__deq_valid = 1'b0;
  endtask

  // Scoreboard: compare every push transfer against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && o__push_valid && i__enqueue_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_push", {o__push_priority, o__push_data}, 32'hx);
      end else begin
        check("push", {o__push_priority, o__push_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset            = 1'b1;
    i__pkt_valid     = 1'b0;
    i__pkt_flow      = '0;
    i__pkt_len       = '0;
    i__pkt_payload   = '0;
    i__enqueue_ready = 1'b1;
    i__deq_valid     = 1'b0;
    i__deq_tag       = '0;
    i__clear_all     = 1'b0;
`ifdef PIFO_RANK_WEIGHT_EN
    i__cfg_valid     = 1'b0;
    i__cfg_flow      = '0;
    i__cfg_shift     = '0;
`endif
    repeat (3) tick();
    check("reset_push_valid", 32'(o__push_valid), 32'd0);
    check("reset_prio", 32'(o__push_priority), 32'd0);
    check("reset_data", 32'(o__push_data), 32'd0);
    check("reset_vt", 32'(o__virtual_time), 32'd0);
    check("reset_pkt_ready", 32'(o__pkt_ready), 32'd0);
    reset = 1'b0;
    tick();

    // Single flow, back-to-back
    send(4'd1, 8'd10, 8'h11, 8'd255, 16'd0);
    send(4'd1, 8'd10, 8'h12, 8'd245, 16'd10);
    send(4'd1, 8'd10, 8'h13, 8'd235, 16'd20);

    // Two flows interleaved
    send(4'd2, 8'd10, 8'h21, 8'd255, 16'd0);
    send(4'd3, 8'd10, 8'h31, 8'd255, 16'd0);
    send(4'd2, 8'd10, 8'h22, 8'd245, 16'd10);
    send(4'd3, 8'd10, 8'h32, 8'd245, 16'd10);
    repeat (2) tick();

    // Backpressure with a second packet waiting
    i__enqueue_ready = 1'b0;
    send(4'd4, 8'd5, 8'h41, 8'd255, 16'd0);
    i__pkt_valid   = 1'b1;
    i__pkt_flow    = 4'd5;
    i__pkt_len     = 8'd9;
    i__pkt_payload = 8'h51;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_pkt_ready", 32'(o__pkt_ready), 32'd0);
      check("bp_push_valid", 32'(o__push_valid), 32'd1);
      check("bp_hold", {o__push_priority, o__push_data}, {8'd255, 16'd0, 8'h41});
    end
    @(posedge clk);
    #1;
    exp_q.push_back({8'd255, 16'd0, 8'h51});
    i__enqueue_ready = 1'b1;
    tick();
    i__pkt_valid = 1'b0;
    repeat (2) tick();

    // Same-cycle accept and deq: accept sees old V
    i__deq_valid = 1'b1;
    i__deq_tag   = 16'd50;
    send(4'd6, 8'd7, 8'h61, 8'd255, 16'd0);
    i__deq_valid = 1'b0;
    check("vt_after_deq50", 32'(o__virtual_time), 32'd50);

    // Walk V to 0xFFF0 while keeping flow 0 inside the tag span
    deq(16'h7000);
    send(4'd0, 8'd0, 8'h01, 8'd255, 16'h7000);
    deq(16'hE000);
    send(4'd0, 8'd0, 8'h02, 8'd255, 16'hE000);
    deq(16'hFFF0);
    check("vt_fff0", 32'(o__virtual_time), 32'hFFF0);
    deq(16'h8000);
    check("vt_monotonic", 32'(o__virtual_time), 32'hFFF0);
    send(4'd0, 8'h20, 8'h03, 8'd255, 16'hFFF0);
    deq(16'h0005);
    check("vt_wrap", 32'(o__virtual_time), 32'h0005);
    send(4'd0, 8'hFF, 8'h04, 8'd244, 16'h0010);
    send(4'd0, 8'h22, 8'h05, 8'd1, 16'h010F);
    send(4'd0, 8'd0, 8'h06, 8'd1, 16'h0131);
    repeat (2) tick();

    // clear_all while a push is pending
    i__enqueue_ready = 1'b0;
    send(4'd7, 8'd3, 8'h71, 8'd255, 16'd5);
    check("pre_clear_valid", 32'(o__push_valid), 32'd1);
    dropped = exp_q.pop_back();
    i__clear_all = 1'b1;
    tick();
    i__clear_all = 1'b0;
    check("clear_push_valid", 32'(o__push_valid), 32'd0);
    check("clear_prio", 32'(o__push_priority), 32'd0);
    check("clear_data", 32'(o__push_data), 32'd0);
    check("clear_vt", 32'(o__virtual_time), 32'd0);
    i__enqueue_ready = 1'b1;
    send(4'd0, 8'd10, 8'h07, 8'd255, 16'd0);

`ifdef PIFO_RANK_WEIGHT_EN
    i__cfg_valid = 1'b1;
    i__cfg_flow  = 4'd8;
    i__cfg_shift = 3'd1;
    tick();
    i__cfg_valid = 1'b0;
    send(4'd8, 8'd10, 8'h81, 8'd255, 16'd0);
    send(4'd8, 8'd10, 8'h82, 8'd250, 16'd5);
`else
    send(4'd8, 8'd10, 8'h81, 8'd255, 16'd0);
    send(4'd8, 8'd10, 8'h82, 8'd245, 16'd10);
`endif
    repeat (4) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
